// File: rtl/replay_memory_controller_pkg.sv
// ============================================================================
// replay_memory_controller_pkg
// Shared LFSR constants, FSM state encoding and clog2 helper for the
// replay-memory command controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package replay_memory_controller_pkg;

  localparam int c_lfsr_width = 32;
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [c_lfsr_width-1:0] c_lfsr_taps = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Never returns less than 1 so a depth-1 memory still gets a legal address port.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/replay_memory_controller_lfsr.sv
// ============================================================================
// replay_lfsr
// 32-bit Galois LFSR with loadable seed on reset and advance enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module replay_lfsr
  import replay_memory_controller_pkg::*;
#(
  parameter logic [c_lfsr_width-1:0] SEED = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  output logic [c_lfsr_width-1:0] o_state
);

  logic [c_lfsr_width-1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_enable) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ c_lfsr_taps) : (r_state >> 1);
    end
  end

  assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/replay_memory_controller.sv
// ============================================================================
// replay_memory_controller
// Drives the replay RAM port: circular transition writes and LFSR-sampled
// mini-batch reads with per-batch framing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module replay_memory_controller
  import replay_memory_controller_pkg::*;
#(
  parameter int          DATA_WIDTH        = 32,
  parameter int          MEMORY_WIDTH      = 10000,
  parameter int          ACTION_WIDTH      = 2,
  parameter int          BATCH_SIZE        = 32,
  parameter logic [31:0] LFSR_SEED         = 32'hACE1_2468,
  localparam int         MEMORY_ADDR_WIDTH = clog2(MEMORY_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push_valid,
  input  logic [DATA_WIDTH-1:0]        i_current_state_0,
  input  logic [DATA_WIDTH-1:0]        i_current_state_1,
  input  logic [ACTION_WIDTH-1:0]      i_action,
  input  logic [DATA_WIDTH-1:0]        i_reward,
  input  logic [DATA_WIDTH-1:0]        i_next_state_0,
  input  logic [DATA_WIDTH-1:0]        i_next_state_1,
  input  logic                         i_done,
  input  logic                         i_sample_start,
  output logic                         o_ram_valid,
  output logic                         o_ram_rw_select,
  output logic [MEMORY_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]        o_ram_current_state_0,
  output logic [DATA_WIDTH-1:0]        o_ram_current_state_1,
  output logic [ACTION_WIDTH-1:0]      o_ram_action,
  output logic [DATA_WIDTH-1:0]        o_ram_reward,
  output logic [DATA_WIDTH-1:0]        o_ram_next_state_0,
  output logic [DATA_WIDTH-1:0]        o_ram_next_state_1,
  output logic                         o_ram_done,
  output logic                         o_busy,
  output logic                         o_sample_reject,
  output logic                         o_sample_last,
  output logic                         o_batch_done,
  output logic [MEMORY_ADDR_WIDTH:0]   o_count
);

  localparam int                         c_cw        = MEMORY_ADDR_WIDTH + 1;
  localparam logic [c_cw-1:0]            c_batch     = c_cw'(BATCH_SIZE);
  localparam logic [c_cw-1:0]            c_full      = c_cw'(MEMORY_WIDTH);
  localparam logic [c_cw-1:0]            c_cnt_one   = c_cw'(1);
  localparam logic [MEMORY_ADDR_WIDTH-1:0] c_last_addr = MEMORY_ADDR_WIDTH'(MEMORY_WIDTH - 1);
  localparam logic [MEMORY_ADDR_WIDTH-1:0] c_addr_one  = MEMORY_ADDR_WIDTH'(1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [c_cw-1:0]                r_reads_issued;
  logic [c_cw-1:0]                w_reads_next;
  logic [c_cw-1:0]                w_reads_inc;
  logic                           w_issue_read;
  logic                           w_reject;
  logic                           w_drain;
  logic [MEMORY_ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [c_cw-1:0]                r_count;
  logic [c_lfsr_width-1:0]        w_lfsr;
  logic [16+c_cw-1:0]             w_product;
  logic [MEMORY_ADDR_WIDTH-1:0]   w_read_addr;
  logic                           w_unused_bits;

  logic                           r_ram_valid;
  logic                           r_ram_rw_select;
  logic [MEMORY_ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]          r_cs0, r_cs1, r_reward, r_ns0, r_ns1;
  logic [ACTION_WIDTH-1:0]        r_action;
  logic                           r_done;
  logic                           r_busy;
  logic                           r_sample_reject;
  logic                           r_sample_last;
  logic                           r_batch_done;

  replay_lfsr #(
    .SEED     (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .i_enable (1'b1),
    .o_state  (w_lfsr)
  );

  // Scaling a 16-bit uniform value by count keeps the address strictly below count.
  assign w_product     = {{c_cw{1'b0}}, w_lfsr[15:0]} * {16'b0, r_count};
  assign w_read_addr   = w_product[16 +: MEMORY_ADDR_WIDTH];
  assign w_unused_bits = ^{w_lfsr[31:16], w_product[16+c_cw-1], w_product[15:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The first read goes out on the accepting edge so it lands one cycle after start.
  always_comb begin
    w_state_next = r_state;
    w_issue_read = 1'b0;
    w_reject     = 1'b0;
    w_drain      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sample_start) begin
          if (r_count >= c_batch) begin
            w_state_next = ST_SAMPLE;
            w_issue_read = !i_push_valid;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_SAMPLE: w_issue_read = !i_push_valid;
      ST_DRAIN: begin
        w_drain      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_reads_inc  = ((r_state == ST_IDLE) ? '0 : r_reads_issued) + c_cnt_one;
    w_reads_next = (r_state == ST_IDLE) ? '0 : r_reads_issued;
    if (w_issue_read) begin
      w_reads_next = w_reads_inc;
      if (w_reads_inc == c_batch) begin
        w_state_next = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reads_issued  <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_ram_valid     <= 1'b0;
      r_ram_rw_select <= 1'b0;
      r_ram_addr      <= '0;
      r_cs0           <= '0;
      r_cs1           <= '0;
      r_action        <= '0;
      r_reward        <= '0;
      r_ns0           <= '0;
      r_ns1           <= '0;
      r_done          <= 1'b0;
      r_busy          <= 1'b0;
      r_sample_reject <= 1'b0;
      r_sample_last   <= 1'b0;
      r_batch_done    <= 1'b0;
    end else begin
      r_reads_issued  <= w_reads_next;
      r_ram_valid     <= i_push_valid | w_issue_read;
      r_ram_rw_select <= w_issue_read;
      r_busy          <= (w_state_next != ST_IDLE);
      r_sample_reject <= w_reject;
      r_sample_last   <= w_drain;
      r_batch_done    <= w_drain;
      if (i_push_valid) begin
        r_ram_addr <= r_wr_ptr;
        r_cs0      <= i_current_state_0;
        r_cs1      <= i_current_state_1;
        r_action   <= i_action;
        r_reward   <= i_reward;
        r_ns0      <= i_next_state_0;
        r_ns1      <= i_next_state_1;
        r_done     <= i_done;
        r_wr_ptr   <= (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + c_addr_one;
        if (r_count != c_full) begin
          r_count <= r_count + c_cnt_one;
        end
      end else if (w_issue_read) begin
        r_ram_addr <= w_read_addr;
      end
    end
  end

  assign o_ram_valid           = r_ram_valid;
  assign o_ram_rw_select       = r_ram_rw_select;
  assign o_ram_addr            = r_ram_addr;
  assign o_ram_current_state_0 = r_cs0;
  assign o_ram_current_state_1 = r_cs1;
  assign o_ram_action          = r_action;
  assign o_ram_reward          = r_reward;
  assign o_ram_next_state_0    = r_ns0;
  assign o_ram_next_state_1    = r_ns1;
  assign o_ram_done            = r_done;
  assign o_busy                = r_busy;
  assign o_sample_reject       = r_sample_reject;
  assign o_sample_last         = r_sample_last;
  assign o_batch_done          = r_batch_done;
  assign o_count               = r_count;

endmodule

`default_nettype wire

// File: tb/tb_replay_memory_controller.sv
// ============================================================================
// tb_replay_memory_controller
// Self-checking bench: push table, reject, batch timing, interleave, reset.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_replay_memory_controller;

  localparam int          DW   = 32;
  localparam int          MW   = 8;
  localparam int          AW   = 3;
  localparam int          CW   = 4;
  localparam int          BS   = 4;
  localparam int          PW   = 5 * DW + 2 + 1;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_push_valid = 1'b0;
  logic [DW-1:0] i_cs0 = '0, i_cs1 = '0, i_reward = '0, i_ns0 = '0, i_ns1 = '0;
  logic [1:0]    i_action = '0;
  logic          i_done = 1'b0;
  logic          i_sample_start = 1'b0;

  logic          o_ram_valid, o_ram_rw_select;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_cs0, o_cs1, o_reward, o_ns0, o_ns1;
  logic [1:0]    o_action;
  logic          o_done, o_busy, o_sample_reject, o_sample_last, o_batch_done;
  logic [CW-1:0] o_count;

  replay_memory_controller #(
    .DATA_WIDTH   (DW),
    .MEMORY_WIDTH (MW),
    .ACTION_WIDTH (2),
    .BATCH_SIZE   (BS),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_push_valid          (i_push_valid),
    .i_current_state_0     (i_cs0),
    .i_current_state_1     (i_cs1),
    .i_action              (i_action),
    .i_reward              (i_reward),
    .i_next_state_0        (i_ns0),
    .i_next_state_1        (i_ns1),
    .i_done                (i_done),
    .i_sample_start        (i_sample_start),
    .o_ram_valid           (o_ram_valid),
    .o_ram_rw_select       (o_ram_rw_select),
    .o_ram_addr            (o_ram_addr),
    .o_ram_current_state_0 (o_cs0),
    .o_ram_current_state_1 (o_cs1),
    .o_ram_action          (o_action),
    .o_ram_reward          (o_reward),
    .o_ram_next_state_0    (o_ns0),
    .o_ram_next_state_1    (o_ns1),
    .o_ram_done            (o_done),
    .o_busy                (o_busy),
    .o_sample_reject       (o_sample_reject),
    .o_sample_last         (o_sample_last),
    .o_batch_done          (o_batch_done),
    .o_count               (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] cs0, cs1, reward, ns0, ns1;
    logic [1:0]    action;
    logic          done;
    logic [AW-1:0] exp_addr;
    logic [CW-1:0] exp_count;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
    logic [CW-1:0] count;
  } wr_t;

  vec_t          tbl[10];
  wr_t           wq[$];
  wr_t           mon_e;
  logic [AW-1:0] rd_log[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_reads = 0;

  logic [31:0]   m_lfsr = '0, m_lfsr_prev = '0;
  logic [CW-1:0] m_count = '0, m_count_prev = '0;
  logic [AW-1:0] m_wr_ptr = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [19:0]   m_prod;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference LFSR and occupancy, with the values seen just before each edge.
  always @(posedge clk) begin
    m_lfsr_prev  <= m_lfsr;
    m_count_prev <= m_count;
    if (rst) begin
      m_lfsr  <= SEED;
      m_count <= '0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (i_push_valid && m_count != CW'(MW)) m_count <= m_count + CW'(1);
    end
  end

  always @(negedge clk) begin
    if (o_ram_valid === 1'b1) begin
      if (o_ram_rw_select === 1'b0) begin
        if (wq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d with nothing queued", o_ram_addr);
        end else begin
          mon_e = wq.pop_front();
          check("write_addr", 256'(o_ram_addr), 256'(mon_e.addr));
          check("write_data", 256'({o_cs0, o_cs1, o_reward, o_ns0, o_ns1, o_action, o_done}),
                256'(mon_e.data));
          check("write_count", 256'(o_count), 256'(mon_e.count));
        end
      end else begin
        m_prod = {4'b0, m_lfsr_prev[15:0]} * {16'b0, m_count_prev};
        check("read_addr", 256'(o_ram_addr), 256'(m_prod[16 +: AW]));
        check("read_in_range", 256'(o_ram_addr < AW'(m_count_prev - CW'(1)) ||
                                    CW'(o_ram_addr) == m_count_prev - CW'(1)), 256'(1));
        rd_log.push_back(o_ram_addr);
        n_reads++;
      end
    end
  end

  task automatic load_push(input vec_t v);
    i_push_valid = 1'b1;
    i_cs0 = v.cs0; i_cs1 = v.cs1; i_reward = v.reward;
    i_ns0 = v.ns0; i_ns1 = v.ns1; i_action = v.action; i_done = v.done;
    mon_e.addr  = v.exp_addr;
    mon_e.data  = {v.cs0, v.cs1, v.reward, v.ns0, v.ns1, v.action, v.done};
    mon_e.count = v.exp_count;
    wq.push_back(mon_e);
    m_wr_ptr = v.exp_addr + AW'(1);
    m_cnt    = v.exp_count;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.cs0 = $urandom; v.cs1 = $urandom; v.reward = $urandom;
    v.ns0 = $urandom; v.ns1 = $urandom; v.action = 2'($urandom); v.done = 1'($urandom);
    v.exp_addr  = m_wr_ptr;
    v.exp_count = (m_cnt == CW'(MW)) ? CW'(MW) : m_cnt + CW'(1);
    return v;
  endfunction

  task automatic push_one(input vec_t v);
    @(posedge clk); #1;
    i_sample_start = 1'b0;
    load_push(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_push_valid = 1'b0;
      i_sample_start = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; i_push_valid = 1'b0; i_sample_start = 1'b0;
    m_wr_ptr = '0; m_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Bit k of push_mask pushes during the k-th cycle after start (bit 0: with start).
  task automatic run_batch(input logic [15:0] push_mask, input int exp_lat, input int exp_reads);
    int r0;
    int lat;
    r0  = n_reads;
    lat = 0;
    @(posedge clk); #1;
    i_sample_start = 1'b1;
    if (push_mask[0]) load_push(rand_vec()); else i_push_valid = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk); #1;
      i_sample_start = 1'b0;
      if (k < 16 && push_mask[k]) load_push(rand_vec()); else i_push_valid = 1'b0;
      @(negedge clk);
      if (k == 1) check("busy_in_batch", 256'(o_busy), 256'(1));
      if (o_batch_done === 1'b1) begin
        lat = k;
        check("last_with_done", 256'(o_sample_last), 256'(1));
        check("busy_after_batch", 256'(o_busy), 256'(0));
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL batch_timeout: no batch_done within 30 cycles, expected at %0d", exp_lat);
    end else begin
      check("done_latency", 256'(lat), 256'(exp_lat));
    end
    check("reads_in_batch", 256'(n_reads - r0), 256'(exp_reads));
    @(negedge clk);
    check("done_one_cycle", 256'({o_batch_done, o_sample_last}), 256'(0));
  endtask

  task automatic fill_and_sample(input bit skip_reset);
    if (!skip_reset) do_reset();
    for (int i = 0; i < MW; i++) push_one(tbl[i]);
    run_batch(16'h0000, BS + 1, BS);
  endtask

  initial begin
    int r0, a0, b0;
    for (int i = 0; i < 10; i++) begin
      tbl[i].cs0       = 32'h1000_0000 + 32'(i);
      tbl[i].cs1       = 32'h2000_0000 + 32'(i * 3);
      tbl[i].reward    = 32'hFFFF_FF00 ^ 32'(i);
      tbl[i].ns0       = 32'hA5A5_0000 + 32'(i << 4);
      tbl[i].ns1       = ~(32'h0000_1111 * 32'(i + 1));
      tbl[i].action    = 2'(i);
      tbl[i].done      = 1'(i);
      tbl[i].exp_addr  = AW'(i % MW);
      tbl[i].exp_count = CW'((i + 1 > MW) ? MW : i + 1);
    end

    do_reset();
    @(negedge clk);
    check("reset_outputs", 256'({o_ram_valid, o_ram_rw_select, o_ram_addr, o_busy, o_sample_reject,
                                 o_sample_last, o_batch_done, o_cs0, o_done}), 256'(0));
    check("reset_count", 256'(o_count), 256'(0));

    // Ten pushes into depth 8: address wrap and count saturation.
    for (int i = 0; i < 10; i++) push_one(tbl[i]);
    idle(2);
    check("wrap_queue_drained", 256'(wq.size()), 256'(0));
    check("count_saturated", 256'(o_count), 256'(MW));

    // Three entries is below the batch size: refused.
    do_reset();
    for (int i = 0; i < 3; i++) push_one(tbl[i]);
    idle(1);
    r0 = n_reads;
    @(posedge clk); #1; i_sample_start = 1'b1;
    @(posedge clk); #1; i_sample_start = 1'b0;
    @(negedge clk);
    check("reject_pulse", 256'(o_sample_reject), 256'(1));
    check("reject_not_busy", 256'(o_busy), 256'(0));
    @(negedge clk);
    check("reject_one_cycle", 256'(o_sample_reject), 256'(0));
    check("reject_no_reads", 256'(n_reads - r0), 256'(0));

    // Exactly BATCH_SIZE entries, push in the start cycle: write first, one extra cycle.
    push_one(tbl[3]);
    run_batch(16'h0001, BS + 2, BS);
    check("count_after_start_push", 256'(o_count), 256'(5));

    a0 = rd_log.size();
    fill_and_sample(1'b0);

    // Two pushes mid-batch stall reads two cycles.
    run_batch(16'h0006, BS + 3, BS);
    check("interleave_queue_drained", 256'(wq.size()), 256'(0));

    // Reset during SAMPLE.
    @(posedge clk); #1; i_sample_start = 1'b1;
    @(posedge clk); #1; i_sample_start = 1'b0;
    @(posedge clk); #1; rst = 1'b1; m_wr_ptr = '0; m_cnt = '0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 256'({o_ram_valid, o_ram_rw_select, o_ram_addr, o_busy, o_sample_reject,
                                    o_sample_last, o_batch_done, o_cs0, o_done}), 256'(0));
    check("midreset_count", 256'(o_count), 256'(0));

    b0 = rd_log.size();
    fill_and_sample(1'b1);
    for (int i = 0; i < BS; i++) begin
      check("rerun_same_addr", 256'(rd_log[b0 + i]), 256'(rd_log[a0 + i]));
    end
    idle(2);
    check("final_queue_drained", 256'(wq.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/replay_memory_controller.md
# replay_memory_controller

Command-side controller for the experience-replay RAM: the initiator that drives the replay RAM's single valid/read-write/address port. It stores incoming transitions at a circular write pointer and, on request, issues a mini-batch of pseudo-random read addresses drawn from the filled region. Sits between the environment/agent front end (push side) and the DQN training datapath (sample side). Read data goes straight from the RAM to the training datapath; this block only supplies per-sample framing.

## Interface
Parameters:
- DATA_WIDTH, 32, width of state and reward fields
- MEMORY_WIDTH, 10000, replay depth in entries; MEMORY_ADDR_WIDTH = clog2(MEMORY_WIDTH)
- ACTION_WIDTH, 2, action field width
- BATCH_SIZE, 32, reads per mini-batch, 1..MEMORY_WIDTH
- LFSR_SEED, 32'hACE1_2468, nonzero LFSR reset value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_push_valid  in  1  store one transition this cycle
- i_current_state_0/1, i_reward, i_next_state_0/1  in  DATA_WIDTH each  transition fields
- i_action  in  ACTION_WIDTH; i_done  in  1  transition fields
- i_sample_start  in  1  request one mini-batch
- o_ram_valid  out  1  RAM command strobe
- o_ram_rw_select  out  1  0 write, 1 read
- o_ram_addr  out  MEMORY_ADDR_WIDTH  RAM address
- o_ram_current_state_0/1, o_ram_reward, o_ram_next_state_0/1  out  DATA_WIDTH; o_ram_action  out  ACTION_WIDTH; o_ram_done  out  1  RAM write data
- o_busy  out  1  batch in progress (state != IDLE)
- o_sample_reject  out  1  one-cycle pulse: start refused, too few entries
- o_sample_last  out  1  aligned with RAM read-valid of the final sample
- o_batch_done  out  1  one-cycle pulse, same cycle as o_sample_last
- o_count  out  MEMORY_ADDR_WIDTH+1  valid entries stored

## Operation
- All outputs registered; reset value of every output 0. Reset also sets wr_ptr=0, count=0, reads_issued=0, LFSR=LFSR_SEED, state IDLE. RAM contents untouched.
- Push: on i_push_valid, next cycle o_ram_valid=1, rw_select=0, addr=wr_ptr, write data = captured fields. wr_ptr increments, wraps MEMORY_WIDTH-1 → 0. count increments, saturates at MEMORY_WIDTH (oldest entry overwritten).
- Push is always accepted (no ready), in every state; push has priority over sample reads for the port.
- FSM IDLE: i_sample_start with count >= BATCH_SIZE → SAMPLE, reads_issued=0. With count < BATCH_SIZE → stay IDLE, o_sample_reject pulse next cycle. i_sample_start ignored outside IDLE.
- SAMPLE: each cycle without i_push_valid issues one read: rw_select=1, addr = (lfsr[15:0] * count) >> 16 (unsigned, 16 x (MEMORY_ADDR_WIDTH+1) product, result always < count). Cycle with push: read stalls, LFSR still advances. After BATCH_SIZE-th read issued → DRAIN.
- DRAIN: one cycle; o_sample_last=1, o_batch_done=1; → IDLE.
- LFSR: 32-bit Galois, taps 32,22,2,1, advances every cycle out of reset.
- count used for address scaling is the value at issue cycle (grows if pushes interleave).

## Timing
- Push → RAM write command: 1 cycle. Read command at cycle t → RAM read data valid at t+1.
- Start (IDLE, no pushes) → first read command 1 cycle later; last read at start+BATCH_SIZE; o_sample_last/o_batch_done at start+BATCH_SIZE+1.
- Each interleaved push adds exactly one cycle.
- Start and push in same cycle: both accepted; the write command is issued first.
- Reset mid-batch: next cycle IDLE, all outputs 0; RAM read data already in flight not framed.

## Structure
- Shared package: LFSR taps/width, FSM state encoding (IDLE, SAMPLE, DRAIN), clog2 function.
- One sub-module natural: replay_lfsr (seed parameter, enable, 32-bit state out).

## Test plan
- Reset, 3 pushes → RAM writes at addr 0,1,2 with matching data; o_count=3.
- Push MEMORY_WIDTH+2 entries (MEMORY_WIDTH=8) → addresses wrap to 0,1; o_count saturates at 8.
- count=5, BATCH_SIZE=8, start → o_sample_reject pulse, o_busy stays 0, no read issued.
- count=8, BATCH_SIZE=4, start, no pushes → 4 reads on consecutive cycles, all addr<8; last/done 5 cycles after start.
- Same batch with pushes on cycles 2 and 3 → reads stall 2 cycles, writes go to wr_ptr; done at start+7.
- rst asserted during SAMPLE → next cycle IDLE, outputs 0, o_count=0, LFSR restarts from seed (identical address sequence on rerun).
